add8_err_monitor: RTL and testbench

ADD8_ERR_MONITOR -- requirements
Module: add8_err_monitor

---
 rtl/add8_err_monitor.sv | 154 +++++++++++++++
 tb/tb_add8_err_monitor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add8_err_monitor.sv
// Error-metric monitor for an 8-bit adder under test: counts samples, erroneous sums,
// accumulated and worst-case absolute error. Define ADD8_ERR_MSE_EN to add sq_err_sum.
module add8_err_monitor #(
    parameter int unsigned N_SAMPLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [8:0]  O,
    output logic [16:0] sample_cnt,
    output logic [16:0] err_cnt,
    output logic [24:0] abs_err_sum,
    output logic [8:0]  wce,
`ifdef ADD8_ERR_MSE_EN
    output logic [33:0] sq_err_sum,
`endif
    output logic        busy,
    output logic        done
);

    localparam logic [16:0] RUN_LEN  = 17'(N_SAMPLES);
    localparam logic [16:0] LAST_IDX = RUN_LEN - 17'd1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state;
    logic        drain_cnt;
    logic        accept;
    logic        start_run;
    logic [8:0]  exact_sum;
    logic signed [9:0] delta;
    logic [8:0]  abs_diff;
    logic        s1_valid;
    logic [8:0]  s1_diff;

    assign in_ready  = (state == RUN) && (sample_cnt < RUN_LEN);
    assign accept    = in_valid && in_ready;
    assign start_run = start && !clear && (state == IDLE || state == DONE);

    // Difference is taken at 10-bit signed width so O - (A+B) never wraps; its
    // magnitude fits in 9 bits because both operands lie in 0..511.
    assign exact_sum = {1'b0, A} + {1'b0, B};
    assign delta     = $signed({1'b0, O}) - $signed({1'b0, exact_sum});
    assign abs_diff  = delta[9] ? 9'(-delta) : 9'(delta);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept && sample_cnt == LAST_IDX) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Two drain cycles let the last accepted sample clear both stages.
                    if (drain_cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (clear || start_run) begin
            sample_cnt <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 17'd1;
        end
    end

    // Stage 1: only the error magnitude travels on; the exact sum is consumed here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_diff <= abs_diff;
            end
        end
    end

`ifdef ADD8_ERR_MSE_EN
    logic [17:0] sq_diff;
    assign sq_diff = s1_diff * s1_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_err_sum <= '0;
        end else if (clear || start_run) begin
            sq_err_sum <= '0;
        end else if (s1_valid) begin
            sq_err_sum <= sq_err_sum + 34'(sq_diff);
        end
    end
`endif

    // Stage 2: accumulate; widths cover 511 * 65536 without saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt     <= '0;
            abs_err_sum <= '0;
            wce         <= '0;
        end else if (clear || start_run) begin
            err_cnt     <= '0;
            abs_err_sum <= '0;
            wce         <= '0;
        end else if (s1_valid) begin
            if (s1_diff != 9'd0) begin
                err_cnt <= err_cnt + 17'd1;
            end
            abs_err_sum <= abs_err_sum + 25'(s1_diff);
            if (s1_diff > wce) begin
                wce <= s1_diff;
            end
        end
    end

endmodule

// File: tb/tb_add8_err_monitor.sv
// Self-checking bench for add8_err_monitor: several instances with different run lengths
// share the sample bus; results are compared against a plain-arithmetic error model.
module tb_add8_err_monitor;

    localparam int NI = 5;
    localparam int NS [NI] = '{1, 2, 3, 4, 8};

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic [NI-1:0] start;
    logic [7:0]    A;
    logic [7:0]    B;
    logic [8:0]    O;
    logic          in_ready    [NI];
    logic          busy        [NI];
    logic          done        [NI];
    logic [16:0]   sample_cnt  [NI];
    logic [16:0]   err_cnt     [NI];
    logic [24:0]   abs_err_sum [NI];
    logic [8:0]    wce         [NI];
`ifdef ADD8_ERR_MSE_EN
    logic [33:0]   sq_err_sum  [NI];
`endif

    int     checks = 0;
    int     errors = 0;
    int     ref_cnt, ref_err, ref_abs, ref_wce;
    longint ref_sq;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        add8_err_monitor #(.N_SAMPLES(NS[g])) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[g]),
            .clear       (clear),
            .in_valid    (in_valid),
            .in_ready    (in_ready[g]),
            .A           (A),
            .B           (B),
            .O           (O),
            .sample_cnt  (sample_cnt[g]),
            .err_cnt     (err_cnt[g]),
            .abs_err_sum (abs_err_sum[g]),
            .wce         (wce[g]),
`ifdef ADD8_ERR_MSE_EN
            .sq_err_sum  (sq_err_sum[g]),
`endif
            .busy        (busy[g]),
            .done        (done[g])
        );
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        ref_cnt = 0;
        ref_err = 0;
        ref_abs = 0;
        ref_wce = 0;
        ref_sq  = 0;
    endtask

    task automatic modelAdd(input int a, input int b, input int o);
        int d;
        d = o - (a + b);
        if (d < 0) d = -d;
        ref_cnt++;
        if (d != 0) ref_err++;
        ref_abs += d;
        if (d > ref_wce) ref_wce = d;
        ref_sq += longint'(d) * longint'(d);
    endtask

    task automatic randomSample(output logic [7:0] a, output logic [7:0] b, output logic [8:0] o);
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) o = {1'b0, a} + {1'b0, b};
        else o = 9'($urandom_range(0, 511));
    endtask

    task automatic pulseStart(input int idx);
        start[idx] = 1'b1;
        step();
        start[idx] = 1'b0;
    endtask

    // Presents one sample for one cycle; the sample is expected to be accepted.
    task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
        A = a;
        B = b;
        O = o;
        in_valid = 1'b1;
        checkOutput("in_ready", 64'(in_ready[idx]), 64'd1);
        modelAdd(int'(a), int'(b), int'(o));
        step();
        in_valid = 1'b0;
    endtask

    task automatic checkResults(input int idx);
        checkOutput("sample_cnt", 64'(sample_cnt[idx]), 64'(ref_cnt));
        checkOutput("err_cnt", 64'(err_cnt[idx]), 64'(ref_err));
        checkOutput("abs_err_sum", 64'(abs_err_sum[idx]), 64'(ref_abs));
        checkOutput("wce", 64'(wce[idx]), 64'(ref_wce));
`ifdef ADD8_ERR_MSE_EN
        checkOutput("sq_err_sum", 64'(sq_err_sum[idx]), 64'(ref_sq));
`endif
    endtask

    task automatic checkIdleZero(input int idx);
        checkOutput("idle_busy", 64'(busy[idx]), 64'd0);
        checkOutput("idle_done", 64'(done[idx]), 64'd0);
        checkOutput("idle_ready", 64'(in_ready[idx]), 64'd0);
        modelClear();
        checkResults(idx);
    endtask

    // Called in the first cycle after the last acceptance: two DRAIN cycles, then DONE.
    task automatic finishRun(input int idx);
        checkOutput("drain1_busy", 64'(busy[idx]), 64'd1);
        checkOutput("drain1_done", 64'(done[idx]), 64'd0);
        step();
        checkOutput("drain2_done", 64'(done[idx]), 64'd0);
        step();
        checkOutput("done", 64'(done[idx]), 64'd1);
        checkOutput("done_busy", 64'(busy[idx]), 64'd0);
        checkResults(idx);
    endtask

    task automatic randomRun(input int idx, input int n);
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] o;
        for (int i = 0; i < n; i++) begin
            randomSample(a, b, o);
            applyStimulus(idx, a, b, o);
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] o;

        rst = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        start = '0;
        A = '0;
        B = '0;
        O = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) checkIdleZero(i);
        rst = 1'b0;
        step();

        $display("[TB] no acceptance before start");
        in_valid = 1'b1;
        A = 8'd3;
        B = 8'd4;
        O = 9'd9;
        for (int c = 0; c < 2; c++) begin
            checkOutput("prestart_ready", 64'(in_ready[3]), 64'd0);
            step();
        end
        in_valid = 1'b0;
        checkIdleZero(3);

        $display("[TB] exact adder, 4 samples");
        modelClear();
        pulseStart(3);
        checkOutput("run_busy", 64'(busy[3]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            applyStimulus(3, a, b, {1'b0, a} + {1'b0, b});
        end
        finishRun(3);

        $display("[TB] single worst-case error");
        modelClear();
        pulseStart(0);
        applyStimulus(0, 8'd255, 8'd255, 9'd0);
        finishRun(0);
        checkOutput("single_wce_const", 64'(wce[0]), 64'd510);

        $display("[TB] backpressure, N_SAMPLES=2");
        modelClear();
        pulseStart(1);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            randomSample(a, b, o);
            A = a;
            B = b;
            O = o;
            checkOutput("bp_ready", 64'(in_ready[1]), (c < 2) ? 64'd1 : 64'd0);
            checkOutput("bp_done", 64'(done[1]), (c == 4) ? 64'd1 : 64'd0);
            checkOutput("bp_busy", 64'(busy[1]), (c < 4) ? 64'd1 : 64'd0);
            if (c < 2) modelAdd(int'(a), int'(b), int'(o));
            step();
        end
        in_valid = 1'b0;
        checkResults(1);

        $display("[TB] mixed errors, start during run ignored");
        modelClear();
        pulseStart(2);
        applyStimulus(2, 8'd10, 8'd20, 9'd25);
        start[2] = 1'b1;
        applyStimulus(2, 8'd0, 8'd0, 9'd7);
        start[2] = 1'b0;
        checkOutput("ignored_start_cnt", 64'(sample_cnt[2]), 64'd2);
        checkOutput("ignored_start_busy", 64'(busy[2]), 64'd1);
        applyStimulus(2, 8'd100, 8'd1, 9'd101);
        finishRun(2);
        checkOutput("mixed_abs_const", 64'(abs_err_sum[2]), 64'd12);

        $display("[TB] clear and start in the same cycle");
        clear = 1'b1;
        start[2] = 1'b1;
        step();
        clear = 1'b0;
        start[2] = 1'b0;
        checkIdleZero(2);
        step();
        checkIdleZero(2);

        $display("[TB] random run and restart from DONE");
        modelClear();
        pulseStart(4);
        randomRun(4, 8);
        finishRun(4);
        pulseStart(4);
        modelClear();
        checkResults(4);
        checkOutput("restart_busy", 64'(busy[4]), 64'd1);

        $display("[TB] async reset after 3 of 8");
        randomRun(4, 3);
        rst = 1'b1;
        #1;
        checkIdleZero(4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        checkIdleZero(4);
        modelClear();
        pulseStart(4);
        randomRun(4, 8);
        finishRun(4);

        $display("[TB] clear after 3 of 8");
        modelClear();
        pulseStart(4);
        randomRun(4, 3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        checkIdleZero(4);
        step();
        step();
        checkIdleZero(4);
        modelClear();
        pulseStart(4);
        randomRun(4, 8);
        finishRun(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
